// File: rtl/usb_defs_pkg.sv
// Shared definitions for the simplified USB full-speed device core.
// Holds the PID codes, the standard request and descriptor codes used by
// EP0, and the small enums shared between the top level and EP0.
package usb_defs_pkg;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [7:0] REQ_GET_DESCRIPTOR = 8'h06;
    localparam logic [7:0] REQ_SET_ADDRESS    = 8'h05;
    localparam logic [7:0] DESC_TYPE_DEVICE   = 8'h01;

    localparam logic [7:0] BMREQ_DEV_TO_HOST = 8'h80;
    localparam logic [7:0] BMREQ_HOST_TO_DEV = 8'h00;

    localparam logic [15:0] DEV_DESC_LEN = 16'd18;

    // What the data bytes following the last accepted token belong to.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_SETUP = 2'd1,
        RX_OUT   = 2'd2
    } rx_mode_e;

    // Where the payload bytes of the current transmit burst come from.
    typedef enum logic [1:0] {
        TX_SRC_NONE = 2'd0,
        TX_SRC_ROM  = 2'd1,
        TX_SRC_FIFO = 2'd2
    } tx_src_e;

endpackage

// File: rtl/usb_ctrl_ep0.sv
// EP0 control endpoint: captures the 8-byte SETUP packet, decodes the
// request once the last byte arrives and holds the device descriptor ROM.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   setup_start         accepted SETUP token to EP0, restarts byte capture
//   setup_byte_valid    good (non-corrupt) SETUP data byte this cycle
//   setup_byte          the data byte
//   setup_last          this byte completes the 8-byte SETUP packet
//   resp_valid          one-cycle pulse the cycle after the last byte
//   resp_pid/resp_len   response packet PID and payload length
//   resp_set_addr       response is the SET_ADDRESS status stage
//   resp_addr           new device address for SET_ADDRESS
//   rom_idx/rom_data    descriptor ROM read port
module usb_ctrl_ep0
    import usb_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        setup_start,
    input  logic        setup_byte_valid,
    input  logic [7:0]  setup_byte,
    output logic        setup_last,
    output logic        resp_valid,
    output logic [3:0]  resp_pid,
    output logic [15:0] resp_len,
    output logic        resp_set_addr,
    output logic [6:0]  resp_addr,
    input  logic [4:0]  rom_idx,
    output logic [7:0]  rom_data
);

    logic [7:0]  setup_q [0:7];
    logic [2:0]  byte_cnt;
    logic [15:0] w_value;
    logic [15:0] w_length;
    logic        is_get_dev_desc;
    logic        is_set_addr;
    logic        unused_setup_bits;

    assign setup_last = setup_byte_valid && (byte_cnt == 3'd7);

    assign w_value  = {setup_q[3], setup_q[2]};
    assign w_length = {setup_q[7], setup_q[6]};

    assign is_get_dev_desc = (setup_q[0] == BMREQ_DEV_TO_HOST) &&
                             (setup_q[1] == REQ_GET_DESCRIPTOR) &&
                             (w_value[15:8] == DESC_TYPE_DEVICE);
    assign is_set_addr     = (setup_q[0] == BMREQ_HOST_TO_DEV) &&
                             (setup_q[1] == REQ_SET_ADDRESS);

    // wIndex and the top address bit play no part in the supported requests.
    assign unused_setup_bits = ^{setup_q[4], setup_q[5], w_value[7]};

    // Byte capture. A fresh SETUP token always restarts at byte 0, so an
    // aborted (corrupt) packet simply leaves a stale count that is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= 3'd0;
            resp_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                setup_q[i] <= 8'h00;
            end
        end else begin
            resp_valid <= setup_last;
            if (setup_start) begin
                byte_cnt <= 3'd0;
            end else if (setup_byte_valid) begin
                setup_q[byte_cnt] <= setup_byte;
                byte_cnt          <= byte_cnt + 3'd1;
            end
        end
    end

    // Request decode, evaluated from the captured bytes while resp_valid.
    always_comb begin
        resp_pid      = 4'h0;
        resp_len      = 16'd0;
        resp_set_addr = 1'b0;
        resp_addr     = 7'd0;
        if (resp_valid) begin
            if (is_get_dev_desc) begin
                resp_pid = PID_DATA1;
                resp_len = (w_length > DEV_DESC_LEN) ? DEV_DESC_LEN : w_length;
            end else if (is_set_addr) begin
                resp_pid      = PID_DATA1;
                resp_set_addr = 1'b1;
                resp_addr     = w_value[6:0];
            end else begin
                resp_pid = PID_STALL;
            end
        end
    end

    // Device descriptor: USB 1.1, max packet 64, VID 1234, PID 5678, 1 config.
    always_comb begin
        case (rom_idx)
            5'd0:    rom_data = 8'h12;
            5'd1:    rom_data = 8'h01;
            5'd2:    rom_data = 8'h10;
            5'd3:    rom_data = 8'h01;
            5'd4:    rom_data = 8'h00;
            5'd5:    rom_data = 8'h00;
            5'd6:    rom_data = 8'h00;
            5'd7:    rom_data = 8'h40;
            5'd8:    rom_data = 8'h34;
            5'd9:    rom_data = 8'h12;
            5'd10:   rom_data = 8'h78;
            5'd11:   rom_data = 8'h56;
            5'd12:   rom_data = 8'h00;
            5'd13:   rom_data = 8'h01;
            5'd14:   rom_data = 8'h01;
            5'd15:   rom_data = 8'h02;
            5'd16:   rom_data = 8'h03;
            5'd17:   rom_data = 8'h01;
            default: rom_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/usb_top.sv
// Simplified USB full-speed device controller core at byte/packet level.
// Decodes host tokens, routes SETUP bytes to EP0, loops EP1 OUT data back
// on EP1 IN through a small FIFO and drives transmit bursts to the host.
// Ports:
//   clk, rst_n                  clock / async active-low reset
//   host_pkt_valid              token strobe (when host_data_valid is 0)
//   host_pid/addr/ep            token fields
//   host_data/host_data_valid   one data byte per strobe
//   host_data_len               declared payload length (not used)
//   host_crc_err                current token or byte is corrupt
//   host_tx_valid/pid/data/len  transmit burst to host
//   dbg_addr_reg                current device address
//   dbg_ep1_fifo_level          EP1 FIFO occupancy
module usb_top
    import usb_defs_pkg::*;
#(
    parameter int EP1_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        host_pkt_valid,
    input  logic [3:0]  host_pid,
    input  logic [6:0]  host_addr,
    input  logic [3:0]  host_ep,
    input  logic [7:0]  host_data,
    input  logic        host_data_valid,
    input  logic [15:0] host_data_len,
    input  logic        host_crc_err,
    output logic        host_tx_valid,
    output logic [3:0]  host_tx_pid,
    output logic [7:0]  host_tx_data,
    output logic [15:0] host_tx_len,
    output logic [6:0]  dbg_addr_reg,
    output logic [3:0]  dbg_ep1_fifo_level
);

    localparam int PTR_W = (EP1_DEPTH > 1) ? $clog2(EP1_DEPTH) : 1;

    rx_mode_e    rx_mode;
    rx_mode_e    rx_mode_next;
    logic [6:0]  dev_addr;
    logic        data_toggle;

    logic [7:0]  fifo_mem [0:EP1_DEPTH-1];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [3:0]  fifo_level;
    logic        fifo_push;
    logic        fifo_pop;

    logic        tx_valid;
    logic [3:0]  tx_pid;
    logic [15:0] tx_len;
    logic [15:0] tx_cnt;
    logic [4:0]  tx_idx;
    tx_src_e     tx_src;
    logic        tx_last;
    logic        addr_pending;
    logic [6:0]  addr_pending_val;

    logic        tok_strobe;
    logic        busy;
    logic        tok_ok;
    logic        setup_tok;
    logic        out_tok;
    logic        in_tok;
    logic        setup_byte_valid;

    logic        ep0_setup_last;
    logic        ep0_resp_valid;
    logic [3:0]  ep0_resp_pid;
    logic [15:0] ep0_resp_len;
    logic        ep0_resp_set_addr;
    logic [6:0]  ep0_resp_addr;
    logic [7:0]  ep0_rom_data;
    logic        unused_host_len;

    assign unused_host_len = ^host_data_len;

    // Tokens are ignored while a response is being sent or is about to start.
    assign tok_strobe = host_pkt_valid && !host_data_valid;
    assign busy       = tx_valid || ep0_resp_valid;
    assign tok_ok     = tok_strobe && !host_crc_err && !busy && (host_addr == dev_addr);
    assign setup_tok  = tok_ok && (host_pid == PID_SETUP) && (host_ep == 4'd0);
    assign out_tok    = tok_ok && (host_pid == PID_OUT)   && (host_ep == 4'd1);
    assign in_tok     = tok_ok && (host_pid == PID_IN)    && (host_ep == 4'd1);

    assign setup_byte_valid = host_data_valid && !host_crc_err && (rx_mode == RX_SETUP);
    assign fifo_push = host_data_valid && !host_crc_err && (rx_mode == RX_OUT) &&
                       (fifo_level != 4'(EP1_DEPTH));
    assign fifo_pop  = tx_valid && (tx_src == TX_SRC_FIFO);
    assign tx_last   = tx_valid && (tx_cnt == 16'd1);

    usb_ctrl_ep0 u_ep0 (
        .clk              (clk),
        .rst_n            (rst_n),
        .setup_start      (setup_tok),
        .setup_byte_valid (setup_byte_valid),
        .setup_byte       (host_data),
        .setup_last       (ep0_setup_last),
        .resp_valid       (ep0_resp_valid),
        .resp_pid         (ep0_resp_pid),
        .resp_len         (ep0_resp_len),
        .resp_set_addr    (ep0_resp_set_addr),
        .resp_addr        (ep0_resp_addr),
        .rom_idx          (tx_idx),
        .rom_data         (ep0_rom_data)
    );

    // Receive-mode state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_mode <= RX_IDLE;
        end else begin
            rx_mode <= rx_mode_next;
        end
    end

    // Any token seen ends the previous data phase, even one for another
    // device or endpoint. A corrupt SETUP byte aborts the control transfer.
    always_comb begin
        rx_mode_next = rx_mode;
        if (tok_strobe && !busy) begin
            if (setup_tok) begin
                rx_mode_next = RX_SETUP;
            end else if (out_tok) begin
                rx_mode_next = RX_OUT;
            end else begin
                rx_mode_next = RX_IDLE;
            end
        end else if (host_data_valid && (rx_mode == RX_SETUP) &&
                     (host_crc_err || ep0_setup_last)) begin
            rx_mode_next = RX_IDLE;
        end
    end

    // EP1 loopback FIFO. Pushes only happen in an OUT data phase and pops
    // only during an IN burst, so the two never coincide in practice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= 4'd0;
            for (int i = 0; i < EP1_DEPTH; i++) begin
                fifo_mem[i] <= 8'h00;
            end
        end else begin
            if (fifo_push) begin
                fifo_mem[wr_ptr] <= host_data;
                wr_ptr <= (wr_ptr == PTR_W'(EP1_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(EP1_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_level <= fifo_level + 4'd1;
                2'b01:   fifo_level <= fifo_level - 4'd1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Transmit burst engine. tx_cnt counts remaining burst cycles; a
    // zero-length packet still occupies one cycle. EP0 responses take
    // precedence because tokens are blocked while one is pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid         <= 1'b0;
            tx_pid           <= 4'h0;
            tx_len           <= 16'd0;
            tx_cnt           <= 16'd0;
            tx_idx           <= 5'd0;
            tx_src           <= TX_SRC_NONE;
            addr_pending     <= 1'b0;
            addr_pending_val <= 7'd0;
        end else if (ep0_resp_valid) begin
            tx_valid         <= 1'b1;
            tx_pid           <= ep0_resp_pid;
            tx_len           <= ep0_resp_len;
            tx_cnt           <= (ep0_resp_len == 16'd0) ? 16'd1 : ep0_resp_len;
            tx_idx           <= 5'd0;
            tx_src           <= (ep0_resp_len == 16'd0) ? TX_SRC_NONE : TX_SRC_ROM;
            addr_pending     <= ep0_resp_set_addr;
            addr_pending_val <= ep0_resp_addr;
        end else if (in_tok) begin
            tx_valid     <= 1'b1;
            tx_idx       <= 5'd0;
            addr_pending <= 1'b0;
            if (fifo_level == 4'd0) begin
                tx_pid <= PID_NAK;
                tx_len <= 16'd0;
                tx_cnt <= 16'd1;
                tx_src <= TX_SRC_NONE;
            end else begin
                tx_pid <= data_toggle ? PID_DATA1 : PID_DATA0;
                tx_len <= {12'd0, fifo_level};
                tx_cnt <= {12'd0, fifo_level};
                tx_src <= TX_SRC_FIFO;
            end
        end else if (tx_valid) begin
            if (tx_cnt == 16'd1) begin
                tx_valid     <= 1'b0;
                tx_pid       <= 4'h0;
                tx_len       <= 16'd0;
                tx_cnt       <= 16'd0;
                tx_idx       <= 5'd0;
                tx_src       <= TX_SRC_NONE;
                addr_pending <= 1'b0;
            end else begin
                tx_cnt <= tx_cnt - 16'd1;
                tx_idx <= tx_idx + 5'd1;
            end
        end
    end

    // The new address only takes effect once the SET_ADDRESS status packet
    // has gone out, so the status stage itself still uses the old address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dev_addr <= 7'd0;
        end else if (tx_last && addr_pending) begin
            dev_addr <= addr_pending_val;
        end
    end

    // EP1 IN data toggle flips with every data (non-NAK) burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_toggle <= 1'b0;
        end else if (in_tok && (fifo_level != 4'd0)) begin
            data_toggle <= ~data_toggle;
        end
    end

    // Payload byte for the current burst cycle; zero outside bursts.
    always_comb begin
        host_tx_data = 8'h00;
        if (tx_valid) begin
            case (tx_src)
                TX_SRC_ROM:  host_tx_data = ep0_rom_data;
                TX_SRC_FIFO: host_tx_data = fifo_mem[rd_ptr];
                default:     host_tx_data = 8'h00;
            endcase
        end
    end

    assign host_tx_valid      = tx_valid;
    assign host_tx_pid        = tx_pid;
    assign host_tx_len        = tx_len;
    assign dbg_addr_reg       = dev_addr;
    assign dbg_ep1_fifo_level = fifo_level;

endmodule

// File: tb/tb_usb_top.sv
// Scoreboard bench for usb_top: stimulus pushes the expected transmit
// cycles into a queue; a negedge monitor pops and compares every cycle
// the device drives host_tx_valid.
module tb_usb_top;
    import usb_defs_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        host_pkt_valid;
    logic [3:0]  host_pid;
    logic [6:0]  host_addr;
    logic [3:0]  host_ep;
    logic [7:0]  host_data;
    logic        host_data_valid;
    logic [15:0] host_data_len;
    logic        host_crc_err;
    logic        host_tx_valid;
    logic [3:0]  host_tx_pid;
    logic [7:0]  host_tx_data;
    logic [15:0] host_tx_len;
    logic [6:0]  dbg_addr_reg;
    logic [3:0]  dbg_ep1_fifo_level;

    typedef struct {
        logic [3:0]  pid;
        logic [15:0] len;
        logic [7:0]  data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ep1_model[$];
    logic       toggle_model;
    int         compared;
    int         mismatched;

    logic [7:0] dev_desc [0:17] = '{8'h12, 8'h01, 8'h10, 8'h01, 8'h00, 8'h00,
                                    8'h00, 8'h40, 8'h34, 8'h12, 8'h78, 8'h56,
                                    8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h01};

    usb_top #(.EP1_DEPTH(8)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .host_pkt_valid     (host_pkt_valid),
        .host_pid           (host_pid),
        .host_addr          (host_addr),
        .host_ep            (host_ep),
        .host_data          (host_data),
        .host_data_valid    (host_data_valid),
        .host_data_len      (host_data_len),
        .host_crc_err       (host_crc_err),
        .host_tx_valid      (host_tx_valid),
        .host_tx_pid        (host_tx_pid),
        .host_tx_data       (host_tx_data),
        .host_tx_len        (host_tx_len),
        .dbg_addr_reg       (dbg_addr_reg),
        .dbg_ep1_fifo_level (dbg_ep1_fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic pkt, input logic [3:0] pid,
                                 input logic [6:0] addr, input logic [3:0] ep,
                                 input logic dv, input logic [7:0] data,
                                 input logic crc);
        @(posedge clk);
        #1;
        host_pkt_valid  = pkt;
        host_pid        = pid;
        host_addr       = addr;
        host_ep         = ep;
        host_data_valid = dv;
        host_data       = data;
        host_crc_err    = crc;
        host_data_len   = dv ? 16'd8 : 16'd0;
        @(posedge clk);
        #1;
        host_pkt_valid  = 1'b0;
        host_pid        = 4'h0;
        host_addr       = 7'd0;
        host_ep         = 4'd0;
        host_data_valid = 1'b0;
        host_data       = 8'h00;
        host_crc_err    = 1'b0;
        host_data_len   = 16'd0;
    endtask

    task automatic sendToken(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
        applyStimulus(1'b1, pid, addr, ep, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendByte(input logic [7:0] data, input logic crc);
        applyStimulus(1'b0, 4'h0, 7'd0, 4'd0, 1'b1, data, crc);
    endtask

    task automatic sendSetup(input logic [6:0] addr, input logic [63:0] req);
        sendToken(PID_SETUP, addr, 4'd0);
        for (int i = 7; i >= 0; i--) begin
            sendByte(req[i*8 +: 8], 1'b0);
        end
    endtask

    task automatic sendOut(input logic [6:0] addr, input logic [7:0] data, input logic crc,
                           input logic accepted);
        sendByte(data, crc);
        if (accepted && !crc && ep1_model.size() < 8) begin
            ep1_model.push_back(data);
        end
    endtask

    task automatic expectDesc(input int n);
        exp_t e;
        if (n == 0) begin
            e.pid = PID_DATA1; e.len = 16'd0; e.data = 8'h00;
            exp_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            e.pid = PID_DATA1; e.len = 16'(n); e.data = dev_desc[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic expectHandshake(input logic [3:0] pid);
        exp_t e;
        e.pid = pid; e.len = 16'd0; e.data = 8'h00;
        exp_q.push_back(e);
    endtask

    task automatic expectFifo(input int n_show);
        exp_t e;
        int   n;
        n = ep1_model.size();
        for (int i = 0; i < n; i++) begin
            e.pid  = toggle_model ? PID_DATA1 : PID_DATA0;
            e.len  = 16'(n);
            e.data = ep1_model.pop_front();
            if (i < n_show) exp_q.push_back(e);
        end
        toggle_model = ~toggle_model;
    endtask

    task automatic checkSetupLatency(input logic [6:0] addr_before);
        @(negedge clk);
        checkOutput("setup_gap_txv", 32'(host_tx_valid), 32'd0);
        @(negedge clk);
        checkOutput("setup_burst_txv", 32'(host_tx_valid), 32'd1);
        checkOutput("addr_during_burst", 32'(dbg_addr_reg), 32'(addr_before));
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while ((host_tx_valid || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        checkOutput({name, "_txv"}, 32'(host_tx_valid), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: every burst cycle must match the next expected entry, and
    // the cycle after a burst must show all tx outputs back at zero.
    initial begin : monitor
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (host_tx_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_tx", 32'(host_tx_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("tx_pid", 32'(host_tx_pid), 32'(e.pid));
                    checkOutput("tx_len", 32'(host_tx_len), 32'(e.len));
                    checkOutput("tx_data", 32'(host_tx_data), 32'(e.data));
                end
            end else if (prev_valid) begin
                checkOutput("idle_pid", 32'(host_tx_pid), 32'd0);
                checkOutput("idle_len", 32'(host_tx_len), 32'd0);
                checkOutput("idle_data", 32'(host_tx_data), 32'd0);
            end
            prev_valid = host_tx_valid;
        end
    end

    initial begin : watchdog
        #100000;
        mismatched++;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        compared        = 0;
        mismatched      = 0;
        toggle_model    = 1'b0;
        rst_n           = 1'b0;
        host_pkt_valid  = 1'b0;
        host_pid        = 4'h0;
        host_addr       = 7'd0;
        host_ep         = 4'd0;
        host_data       = 8'h00;
        host_data_valid = 1'b0;
        host_data_len   = 16'd0;
        host_crc_err    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_txv", 32'(host_tx_valid), 32'd0);
        checkOutput("reset_pid", 32'(host_tx_pid), 32'd0);
        checkOutput("reset_len", 32'(host_tx_len), 32'd0);
        checkOutput("reset_data", 32'(host_tx_data), 32'd0);
        checkOutput("reset_addr", 32'(dbg_addr_reg), 32'd0);
        checkOutput("reset_level", 32'(dbg_ep1_fifo_level), 32'd0);
        rst_n = 1'b1;

        $display("[TB] GET_DESCRIPTOR wLength=255");
        sendSetup(7'h00, 64'h80_06_00_01_00_00_FF_00);
        expectDesc(18);
        checkSetupLatency(7'h00);
        waitIdle("desc18");

        $display("[TB] GET_DESCRIPTOR wLength=8");
        sendSetup(7'h00, 64'h80_06_00_01_00_00_08_00);
        expectDesc(8);
        checkSetupLatency(7'h00);
        waitIdle("desc8");

        $display("[TB] GET_DESCRIPTOR wLength=0");
        sendSetup(7'h00, 64'h80_06_00_01_00_00_00_00);
        expectDesc(0);
        checkSetupLatency(7'h00);
        waitIdle("desc0");

        $display("[TB] unsupported descriptor type");
        sendSetup(7'h00, 64'h80_06_00_02_00_00_40_00);
        expectHandshake(PID_STALL);
        checkSetupLatency(7'h00);
        waitIdle("stall");

        $display("[TB] corrupt SETUP byte aborts");
        sendToken(PID_SETUP, 7'h00, 4'd0);
        sendByte(8'h80, 1'b0);
        sendByte(8'h06, 1'b0);
        sendByte(8'h00, 1'b1);
        for (int i = 0; i < 6; i++) sendByte(8'h01, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("abort_no_tx", 32'(host_tx_valid), 32'd0);

        $display("[TB] EP1 loopback");
        sendToken(PID_OUT, 7'h00, 4'd1);
        sendOut(7'h00, 8'hA1, 1'b0, 1'b1);
        sendOut(7'h00, 8'hB2, 1'b0, 1'b1);
        sendOut(7'h00, 8'hC3, 1'b0, 1'b1);
        checkOutput("level_after_3", 32'(dbg_ep1_fifo_level), 32'd3);
        expectFifo(8);
        sendToken(PID_IN, 7'h00, 4'd1);
        waitIdle("in_abc");
        checkOutput("level_after_in", 32'(dbg_ep1_fifo_level), 32'd0);
        expectHandshake(PID_NAK);
        sendToken(PID_IN, 7'h00, 4'd1);
        waitIdle("in_nak");

        $display("[TB] corrupt OUT byte dropped");
        sendToken(PID_OUT, 7'h00, 4'd1);
        sendOut(7'h00, 8'h11, 1'b0, 1'b1);
        sendOut(7'h00, 8'h22, 1'b1, 1'b1);
        sendOut(7'h00, 8'h33, 1'b0, 1'b1);
        checkOutput("level_crc_drop", 32'(dbg_ep1_fifo_level), 32'd2);
        expectFifo(8);
        sendToken(PID_IN, 7'h00, 4'd1);
        waitIdle("in_toggle");

        $display("[TB] SET_ADDRESS 2A");
        sendSetup(7'h00, 64'h00_05_2A_00_00_00_00_00);
        expectDesc(0);
        checkSetupLatency(7'h00);
        @(negedge clk);
        checkOutput("addr_after_status", 32'(dbg_addr_reg), 32'h2A);
        waitIdle("set_addr");

        sendToken(PID_OUT, 7'h00, 4'd1);
        sendOut(7'h00, 8'h55, 1'b0, 1'b0);
        sendOut(7'h00, 8'h66, 1'b0, 1'b0);
        checkOutput("old_addr_out_ignored", 32'(dbg_ep1_fifo_level), 32'd0);
        sendToken(PID_IN, 7'h00, 4'd1);
        repeat (3) @(negedge clk);
        checkOutput("old_addr_in_ignored", 32'(host_tx_valid), 32'd0);

        $display("[TB] FIFO overflow and reset mid-burst");
        sendToken(PID_OUT, 7'h2A, 4'd1);
        for (int i = 1; i <= 10; i++) sendOut(7'h2A, 8'(i), 1'b0, 1'b1);
        checkOutput("fifo_full_level", 32'(dbg_ep1_fifo_level), 32'd8);
        expectFifo(3);
        sendToken(PID_IN, 7'h2A, 4'd1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_txv", 32'(host_tx_valid), 32'd0);
        checkOutput("rst_pid", 32'(host_tx_pid), 32'd0);
        checkOutput("rst_level", 32'(dbg_ep1_fifo_level), 32'd0);
        checkOutput("rst_addr", 32'(dbg_addr_reg), 32'd0);
        checkOutput("rst_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        ep1_model.delete();
        toggle_model = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] post-reset loopback at address 0");
        sendToken(PID_OUT, 7'h00, 4'd1);
        sendOut(7'h00, 8'h5A, 1'b0, 1'b1);
        expectFifo(8);
        sendToken(PID_IN, 7'h00, 4'd1);
        waitIdle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
